rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Writeback arbiter that owns the single write port of the integer register file. It merges in-order pipeline writebacks with out-of-order results from the multi-cycle unit (divider/multiplier), buffering the latter in a small FIFO. It also keeps a scoreboard of registers with outstanding multi-cycle writes, so decode can stall on RAW/WAW hazards. Sits between the WB stage / multi-cycle unit and the register file's `wen`/`wR`/`wD` inputs.

## Interface
- `FIFO_DEPTH`, 2: multi-cycle result buffer entries; power of two, ≥2.
- `XLEN`, 32: data width.

- `clk`  in  1  global clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pipe_wen`  in  1  WB-stage write request; always accepted, never back-pressured.
- `pipe_wr`  in  5  WB-stage destination register.
- `pipe_wd`  in  XLEN  WB-stage write data.
- `mc_issue`  in  1  multi-cycle op issued this cycle; marks `mc_issue_rd` pending.
- `mc_issue_rd`  in  5  destination of the issued multi-cycle op.
- `mc_valid`  in  1  multi-cycle result valid.
- `mc_ready`  out  1  arbiter can accept a result (FIFO not full).
- `mc_wr`  in  5  result destination register.
- `mc_wd`  in  XLEN  result data.
- `rf_wen`  out  1  register-file write enable (registered).
- `rf_wr`  out  5  register-file write address (registered).
- `rf_wd`  out  XLEN  register-file write data (registered).
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  operands of the instruction in decode.
- `hazard`  out  1  decode instruction touches a pending register.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  buffered results.

## Operation
- Output stage, once per cycle, priority order:
  1. `pipe_wen && pipe_wr != 0`: drive pipe write.
  2. Otherwise FIFO non-empty: pop head, drive it.
  3. Otherwise `rf_wen`=0.
- Writes to x0 (pipe or mc) never assert `rf_wen`. An mc result to x0 is still accepted and popped normally.
- `mc_ready` = registered `fifo_count < FIFO_DEPTH`. It does not account for a same-cycle pop: when full, ready stays 0 even if the FIFO pops that cycle.
- Handshake: a result transfers on `mc_valid && mc_ready`. The unit must hold `mc_wr`/`mc_wd` stable while `mc_valid && !mc_ready`.
- Simultaneous push and pop: count unchanged; FIFO order preserved (strict in-order among mc results).
- Scoreboard: 32-bit `pending`, bit 0 hard-wired 0.
  - Set on `mc_issue` with `mc_issue_rd != 0`.
  - Cleared on the edge where `rf_wen`=1 carries an mc-sourced write to that register. This is the same edge the register file captures the data.
  - Set and clear of the same bit in the same cycle: set wins.
  - Issuing to an already-pending register is illegal; decode prevents it via `hazard`.
- `hazard` (combinational from registered `pending`) = `pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd]`; x0 operands contribute 0.

## Timing
- Reset values: `rf_wen`=0, `rf_wr`=0, `rf_wd`=0, `pending`=0, `fifo_count`=0, `mc_ready`=1, `hazard`=0; FIFO pointers 0.
- Pipe write: `rf_wen` is high 1 cycle after `pipe_wen` is sampled; the register file commits at the following edge.
- mc result via FIFO: earliest `rf_wen` is 2 cycles after handshake (push, then pop).
- Starvation: an mc result waits while `pipe_wen` is continuously asserted. The pipeline bounds this by stalling on `hazard`.
- Reset mid-operation: buffered results and pending bits are discarded; `rf_wen` drops immediately (asynchronous).

## Configuration
- `RF_WB_BYPASS_EN` defined: if the FIFO is empty, no pipe write is accepted this cycle, and an mc handshake occurs, the result goes directly to the output registers. `rf_wen` is high 1 cycle after the handshake, with no FIFO push.
- `RF_WB_BYPASS_EN` undefined: every mc result passes through the FIFO (minimum latency 2).

## Test plan
- Reset, then pipe write x5=0x1234_5678: next cycle `rf_wen`=1, `rf_wr`=5, `rf_wd`=0x1234_5678. Pipe write to x0: `rf_wen` stays 0.
- `mc_issue` rd=7: `hazard`=1 for `dec_rs2`=7. mc result x7=0xDEAD_BEEF with pipe idle: `rf_wen` at handshake+2 (handshake+1 with bypass). `hazard` drops after that edge.
- Continuous `pipe_wen` for 4 cycles while 2 mc results arrive: `fifo_count`=2, `mc_ready`=0, third result held. After `pipe_wen` drops, results are written in arrival order on consecutive cycles.
- FIFO full, pop and `mc_valid` in the same cycle: no push that cycle; `fifo_count` goes 2→1, next cycle ready=1 and the push is accepted.
- `mc_issue` rd=9 in the same cycle as a FIFO pop writing x9 from an older op: `pending[9]` remains 1.
- Assert `rst_n`=0 with 2 buffered results and `pending`=0x0000_0280: all outputs return to reset values immediately; no write is emitted after release.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: pipe writes win, multi-cycle results queue in a FIFO and
// a pending-register scoreboard feeds decode hazards. Optional RF_WB_BYPASS_EN skips the FIFO.
module rf_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned XLEN       = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_wen,
  input  logic [4:0]                    pipe_wr,
  input  logic [XLEN-1:0]               pipe_wd,
  input  logic                          mc_issue,
  input  logic [4:0]                    mc_issue_rd,
  input  logic                          mc_valid,
  output logic                          mc_ready,
  input  logic [4:0]                    mc_wr,
  input  logic [XLEN-1:0]               mc_wd,
  output logic                          rf_wen,
  output logic [4:0]                    rf_wr,
  output logic [XLEN-1:0]               rf_wd,
  input  logic [4:0]                    dec_rs1,
  input  logic [4:0]                    dec_rs2,
  input  logic [4:0]                    dec_rd,
  output logic                          hazard,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]      fifo_wr_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_wd_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic            rf_wen_q, rf_mc_q;
  logic [4:0]      rf_wr_q;
  logic [XLEN-1:0] rf_wd_q;
  logic [31:0]     pending_q, pending_d;

  logic            hs, pipe_take, fifo_empty, pop, push, bypass;
  logic            sel_valid, sel_mc;
  logic [4:0]      sel_wr;
  logic [XLEN-1:0] sel_wd;

  assign mc_ready   = (count_q < CW'(FIFO_DEPTH));
  assign hs         = mc_valid & mc_ready;
  assign pipe_take  = pipe_wen & (pipe_wr != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign pop        = ~pipe_take & ~fifo_empty;

`ifdef RF_WB_BYPASS_EN
  assign bypass = hs & fifo_empty & ~pipe_take;
`else
  assign bypass = 1'b0;
`endif

  assign push    = hs & ~bypass;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_comb begin
    sel_valid = 1'b0;
    sel_mc    = 1'b0;
    sel_wr    = 5'd0;
    sel_wd    = '0;
    if (pipe_take) begin
      sel_valid = 1'b1;
      sel_wr    = pipe_wr;
      sel_wd    = pipe_wd;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_mc    = 1'b1;
      sel_wr    = fifo_wr_q[rd_ptr_q];
      sel_wd    = fifo_wd_q[rd_ptr_q];
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_mc    = 1'b1;
      sel_wr    = mc_wr;
      sel_wd    = mc_wd;
    end
  end

  // Clear follows the committed mc write; a same-cycle issue re-sets the bit afterwards.
  always_comb begin
    pending_d = pending_q;
    if (rf_wen_q && rf_mc_q) pending_d[rf_wr_q] = 1'b0;
    if (mc_issue) pending_d[mc_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_q[wr_ptr_q] <= mc_wr;
      fifo_wd_q[wr_ptr_q] <= mc_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rf_wen_q  <= 1'b0;
      rf_mc_q   <= 1'b0;
      rf_wr_q   <= 5'd0;
      rf_wd_q   <= '0;
      pending_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q   <= count_d;
      pending_q <= pending_d;
      if (sel_valid) begin
        rf_wen_q <= (sel_wr != 5'd0);
        rf_mc_q  <= sel_mc;
        rf_wr_q  <= sel_wr;
        rf_wd_q  <= sel_wd;
      end else begin
        rf_wen_q <= 1'b0;
      end
    end
  end

  assign rf_wen     = rf_wen_q;
  assign rf_wr      = rf_wr_q;
  assign rf_wd      = rf_wd_q;
  assign fifo_count = count_q;
  assign hazard     = pending_q[dec_rs1] | pending_q[dec_rs2] | pending_q[dec_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rf_wb_arbiter;
  localparam int D = 2;
  localparam int X = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pipe_wen = 1'b0;
  logic [4:0]   pipe_wr = '0;
  logic [X-1:0] pipe_wd = '0;
  logic         mc_issue = 1'b0;
  logic [4:0]   mc_issue_rd = '0;
  logic         mc_valid = 1'b0;
  logic         mc_ready;
  logic [4:0]   mc_wr = '0;
  logic [X-1:0] mc_wd = '0;
  logic         rf_wen;
  logic [4:0]   rf_wr;
  logic [X-1:0] rf_wd;
  logic [4:0]   dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic         hazard;
  logic [1:0]   fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit [4:0]     mq_wr[$];
  logic [X-1:0] mq_wd[$];
  bit           m_wen, m_mc;
  bit [4:0]     m_wr;
  logic [X-1:0] m_wd;
  bit [31:0]    m_pend;

  rf_wb_arbiter #(.FIFO_DEPTH(D), .XLEN(X)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wen(pipe_wen), .pipe_wr(pipe_wr), .pipe_wd(pipe_wd),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wr(mc_wr), .mc_wd(mc_wd),
    .rf_wen(rf_wen), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .hazard(hazard), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq_wr.delete();
    mq_wd.delete();
    m_wen = 0; m_mc = 0; m_wr = 0; m_wd = '0; m_pend = '0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    bit           hs, byp;
    bit [4:0]     w;
    logic [X-1:0] d;
    hs  = mc_valid && (mq_wr.size() < D);
    byp = 0;
    if (m_wen && m_mc) m_pend[m_wr] = 0;
    if (mc_issue) m_pend[mc_issue_rd] = 1;
    m_pend[0] = 0;
    if (pipe_wen && pipe_wr != 0) begin
      m_wen = 1; m_mc = 0; m_wr = pipe_wr; m_wd = pipe_wd;
    end else if (mq_wr.size() > 0) begin
      w = mq_wr.pop_front();
      d = mq_wd.pop_front();
      m_wen = (w != 0); m_mc = 1; m_wr = w; m_wd = d;
    end
`ifdef RF_WB_BYPASS_EN
    else if (hs) begin
      byp = 1;
      m_wen = (mc_wr != 0); m_mc = 1; m_wr = mc_wr; m_wd = mc_wd;
    end
`endif
    else m_wen = 0;
    if (hs && !byp) begin
      mq_wr.push_back(mc_wr);
      mq_wd.push_back(mc_wd);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wen = 0; mc_issue = 0; mc_valid = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_clear();
    #3;
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen got %0b want 0", rf_wen); end
    n_checks++; if (rf_wr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_wr got %0d want 0", rf_wr); end
    n_checks++; if (rf_wd !== '0) begin n_fail++; $display("FAIL reset_rf_wd got %h want 0", rf_wd); end
    n_checks++; if (fifo_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_checks++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", mc_ready); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %0b want 0", hazard); end
    do_reset();
  endtask

  task automatic test_pipe_write();
    pipe_wen = 1; pipe_wr = 5; pipe_wd = 32'h1234_5678;
    step();
    pipe_wen = 0;
    n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL pipe_wen got %0b want 1", rf_wen); end
    n_checks++; if (rf_wr !== 5'd5) begin n_fail++; $display("FAIL pipe_wr got %0d want 5", rf_wr); end
    n_checks++; if (rf_wd !== 32'h1234_5678) begin n_fail++; $display("FAIL pipe_wd got %h want 12345678", rf_wd); end
    pipe_wen = 1; pipe_wr = 0; pipe_wd = 32'hFFFF_FFFF;
    step();
    pipe_wen = 0;
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL pipe_x0 got %0b want 0", rf_wen); end
  endtask

  task automatic test_mc_hazard();
    do_reset();
    mc_issue = 1; mc_issue_rd = 7;
    step();
    mc_issue = 0; dec_rs2 = 7;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL mc_hazard_set got %0b want 1", hazard); end
    mc_valid = 1; mc_wr = 7; mc_wd = 32'hDEAD_BEEF;
    step();
    mc_valid = 0;
`ifndef RF_WB_BYPASS_EN
    n_checks++; if (rf_wen !== 1'b0 || fifo_count !== 2'd1) begin
      n_fail++; $display("FAIL mc_queued got wen=%0b count=%0d want wen=0 count=1", rf_wen, fifo_count);
    end
    step();
`endif
    n_checks++; if (rf_wen !== 1'b1 || rf_wr !== 5'd7 || rf_wd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL mc_write got wen=%0b wr=%0d wd=%h want 1/7/deadbeef", rf_wen, rf_wr, rf_wd);
    end
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL mc_hazard_hold got %0b want 1", hazard); end
    step();
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL mc_hazard_clear got %0b want 0", hazard); end
    dec_rs2 = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    pipe_wen = 1; pipe_wr = 1; pipe_wd = 32'h11; mc_valid = 1; mc_wr = 10; mc_wd = 32'hA0;
    step();
    n_checks++; if (fifo_count !== 2'd1) begin n_fail++; $display("FAIL bp_count0 got %0d want 1", fifo_count); end
    pipe_wr = 2; mc_wr = 11; mc_wd = 32'hB0;
    step();
    n_checks++; if (fifo_count !== 2'd2 || mc_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full got count=%0d ready=%0b want 2/0", fifo_count, mc_ready);
    end
    n_checks++; if (rf_wen !== 1'b1 || rf_wr !== 5'd2) begin
      n_fail++; $display("FAIL bp_pipe got wen=%0b wr=%0d want 1/2", rf_wen, rf_wr);
    end
    pipe_wr = 3; mc_wr = 12; mc_wd = 32'hC0;
    step();
    pipe_wr = 4;
    step();
    n_checks++; if (fifo_count !== 2'd2 || mc_ready !== 1'b0 || rf_wr !== 5'd4) begin
      n_fail++; $display("FAIL bp_held got count=%0d ready=%0b wr=%0d want 2/0/4", fifo_count, mc_ready, rf_wr);
    end
    pipe_wen = 0;
    step();  // pop while full: third result not accepted
    n_checks++; if (rf_wen !== 1'b1 || rf_wr !== 5'd10 || rf_wd !== 32'hA0) begin
      n_fail++; $display("FAIL bp_first got wen=%0b wr=%0d wd=%h want 1/10/a0", rf_wen, rf_wr, rf_wd);
    end
    n_checks++; if (fifo_count !== 2'd1 || mc_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_popfull got count=%0d ready=%0b want 1/1", fifo_count, mc_ready);
    end
    step();  // pop and push together
    mc_valid = 0;
    n_checks++; if (rf_wr !== 5'd11 || rf_wd !== 32'hB0 || fifo_count !== 2'd1) begin
      n_fail++; $display("FAIL bp_second got wr=%0d wd=%h count=%0d want 11/b0/1", rf_wr, rf_wd, fifo_count);
    end
    step();
    n_checks++; if (rf_wen !== 1'b1 || rf_wr !== 5'd12 || rf_wd !== 32'hC0 || fifo_count !== 2'd0) begin
      n_fail++; $display("FAIL bp_third got wen=%0b wr=%0d wd=%h count=%0d want 1/12/c0/0",
                         rf_wen, rf_wr, rf_wd, fifo_count);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    mc_issue = 1; mc_issue_rd = 9;
    step();
    mc_issue = 0; mc_valid = 1; mc_wr = 9; mc_wd = 32'h99;
    step();
    mc_valid = 0;
`ifndef RF_WB_BYPASS_EN
    step();
`endif
    n_checks++; if (rf_wen !== 1'b1 || rf_wr !== 5'd9) begin
      n_fail++; $display("FAIL sw_write got wen=%0b wr=%0d want 1/9", rf_wen, rf_wr);
    end
    mc_issue = 1; mc_issue_rd = 9; dec_rd = 9;
    step();
    mc_issue = 0;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sw_pending got %0b want 1", hazard); end
    step();
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sw_persist got %0b want 1", hazard); end
  endtask

  task automatic test_reset_mid();
    // pending[9] carried over from test_set_wins; add pending[7] and two buffered results
    mc_issue = 1; mc_issue_rd = 7; pipe_wen = 1; pipe_wr = 1; pipe_wd = 32'h5;
    mc_valid = 1; mc_wr = 3; mc_wd = 32'h33;
    step();
    mc_issue = 0; pipe_wr = 2; mc_wr = 4; mc_wd = 32'h44;
    step();
    mc_valid = 0; pipe_wen = 0; dec_rs1 = 7; dec_rs2 = 9; dec_rd = 0;
    #1;
    n_checks++; if (fifo_count !== 2'd2 || hazard !== 1'b1) begin
      n_fail++; $display("FAIL rm_pre got count=%0d hazard=%0b want 2/1", fifo_count, hazard);
    end
    rst_n = 0;
    model_clear();
    #1;
    n_checks++; if (rf_wen !== 1'b0 || rf_wr !== 5'd0 || rf_wd !== '0) begin
      n_fail++; $display("FAIL rm_out got wen=%0b wr=%0d wd=%h want 0/0/0", rf_wen, rf_wr, rf_wd);
    end
    n_checks++; if (fifo_count !== 2'd0 || mc_ready !== 1'b1 || hazard !== 1'b0) begin
      n_fail++; $display("FAIL rm_state got count=%0d ready=%0b hazard=%0b want 0/1/0",
                         fifo_count, mc_ready, hazard);
    end
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL rm_post%0d got wen=%0b want 0", i, rf_wen); end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit       hs;
    bit [4:0] rd;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pipe_wen = ($urandom_range(0, 1) == 1);
      pipe_wr  = 5'($urandom);
      pipe_wd  = $urandom;
      if (!mc_valid && $urandom_range(0, 2) == 0) begin
        mc_valid = 1; mc_wr = 5'($urandom); mc_wd = $urandom;
      end
      rd = 5'($urandom_range(1, 31));
      mc_issue    = ($urandom_range(0, 3) == 0) && !m_pend[rd];
      mc_issue_rd = rd;
      dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
      hs = mc_valid && (mq_wr.size() < D);
      step();
      if (hs) mc_valid = 0;
      n_checks++; if (rf_wen !== m_wen) begin
        n_fail++; $display("FAIL rnd_wen c=%0d got %0b want %0b", c, rf_wen, m_wen);
      end
      if (m_wen) begin
        n_checks++; if (rf_wr !== m_wr || rf_wd !== m_wd) begin
          n_fail++; $display("FAIL rnd_data c=%0d got %0d/%h want %0d/%h", c, rf_wr, rf_wd, m_wr, m_wd);
        end
      end
      n_checks++; if (fifo_count !== 2'(mq_wr.size()) || mc_ready !== (mq_wr.size() < D)) begin
        n_fail++; $display("FAIL rnd_fifo c=%0d got count=%0d ready=%0b want %0d", c, fifo_count, mc_ready,
                           mq_wr.size());
      end
      n_checks++; if (hazard !== (m_pend[dec_rs1] | m_pend[dec_rs2] | m_pend[dec_rd])) begin
        n_fail++; $display("FAIL rnd_hazard c=%0d got %0b", c, hazard);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_mc_hazard();
    test_backpressure();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
